fetch: RTL
==========

Name: fetch

Overview:
- Instruction-fetch front end; the producer side of the decode input interface.
- Issues in-order 32-bit instruction reads to the instruction memory and buffers returned words in a small queue.
- Presents one instruction per cycle to decode on valid_de0/instr_de0/pc_de0, with stall backpressure from decode.
- Supports a redirect (branch/flush) that discards queued and in-flight instructions.

Parameters:
- DEPTH, 4: instruction queue entries; also the cap on outstanding requests plus queued entries. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC after reset. Must be 4-byte aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts the request this cycle.
- req_addr  out  32  request byte address, 4-byte aligned.
- rsp_valid  in  1  read data returning; one response per accepted request, in order.
- rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored and treated as 0.
- valid_de0  out  1  instruction presented to decode.
- instr_de0  out  32  instruction word (t_rv_instr layout).
- pc_de0  out  32  PC of instr_de0.
- stall_de0  in  1  decode cannot accept; the head entry is held.

Behaviour:
- Reset is asynchronous and active-low.
  - While asserted: req_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
  - Outputs during reset: valid_de0=0, req_valid=0, instr_de0=0, pc_de0=0.
  - Reset asserted mid-operation discards all state immediately. Responses arriving after deassert with outstanding=0 are an assertion error.
- Credit rule: req_valid = !redirect_valid && (outstanding + drop_cnt + count < DEPTH).
  - req_valid is combinational from state and redirect_valid. req_addr = req_pc.
  - Transfer on req_valid && req_ready: req_pc += 4 (wraps mod 2^32), outstanding++.
- Response handling on rsp_valid:
  - If drop_cnt > 0: drop_cnt-- and the data is discarded.
  - Otherwise: outstanding--, push {rsp_pc, rsp_data} to the queue, rsp_pc += 4.
  - The credit rule guarantees the push never overflows. A push while full is an assertion error, as is rsp_valid with outstanding+drop_cnt==0.
- Output side:
  - valid_de0 = queue non-empty; instr_de0/pc_de0 = head entry (registered storage, no bypass).
  - Minimum latency from rsp_valid to valid_de0 is 1 cycle.
  - Pop on valid_de0 && !stall_de0.
  - Outputs are stable while valid_de0 && stall_de0.
  - instr_de0/pc_de0 are don't-care when valid_de0=0 but must not be X.
- Simultaneous push and pop is allowed at any occupancy, including full and empty. Count is unchanged when both occur while non-empty.
- Redirect has priority over everything else in that cycle. Next state:
  - Queue emptied; the pop in that cycle is ignored.
  - req_pc = rsp_pc = {redirect_pc[31:2],2'b0}.
  - drop_cnt = drop_cnt + outstanding - (rsp_valid && drop_cnt==0 ? 1 : 0) - (rsp_valid && drop_cnt>0 ? 1 : 0). Equivalently: every in-flight response, including one arriving in the redirect cycle, is dropped exactly once.
  - outstanding = 0.
  - No request is issued in the redirect cycle. First new request can be issued the following cycle.
  - valid_de0=0 the cycle after the redirect.
- Back-to-back redirects are legal; each recomputes drop_cnt from the current state.
- Counters outstanding, drop_cnt and count are sized clog2(DEPTH)+1 bits. Their sum never exceeds DEPTH.

Test Plan:
- Reset then stream: req_ready=1, memory returns data 1 cycle after request, stall_de0=0 → req_addr 0,4,8,…; valid_de0 first high 3 cycles after reset deassert; pc_de0 increments by 4 each cycle, instr_de0 matches memory.
- Backpressure: hold stall_de0=1 → exactly DEPTH=4 requests issued, then req_valid=0; queue holds pc 0..12. Release stall → entries drain in order and requests resume.
- Redirect with 2 responses in flight: redirect_pc=32'h100 → both late responses are discarded; next valid_de0 shows pc_de0=32'h100 with the word from address 0x100.
- Redirect in the same cycle as rsp_valid and a decode pop → the arriving response is dropped, the pop is ignored, and valid_de0=0 next cycle. redirect_pc=32'h203 yields req_addr=32'h200.
- PC wrap: redirect_pc=32'hFFFF_FFFC → requests go to FFFF_FFFC then 0000_0000, and pc_de0 follows.
- Reset asserted mid-stream with a full queue and outstanding requests → outputs zero immediately (asynchronously); after deassert fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch front end: credit-limited in-order memory reads feeding a
// small instruction queue that presents one instruction per cycle to decode.
module fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_de0,
  output logic [31:0] instr_de0,
  output logic [31:0] pc_de0,
  input  logic        stall_de0
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [31:0]     req_pc;
  logic [31:0]     rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW:0]     used;
  logic            fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [31:0]     redirect_base;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign redirect_base  = {redirect_pc[31:2], 2'b00};

  // Every slot is either queued, in flight, or owed a drop; never exceed DEPTH.
  assign used      = {1'b0, outstanding} + {1'b0, drop_cnt} + {1'b0, count};
  assign req_valid = reset && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign req_addr  = req_pc;

  assign fire     = req_valid && req_ready;
  assign rsp_drop = rsp_valid && (drop_cnt != '0);
  assign push     = rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = valid_de0 && !stall_de0 && !redirect_valid;

  // NOTE: the storage array has no reset; the head is masked to zero when the
  // queue is empty, so decode never sees X and reset drives the outputs to 0.
  assign valid_de0 = (count != '0);
  assign instr_de0 = valid_de0 ? mem[rd_ptr].instr : '0;
  assign pc_de0    = valid_de0 ? mem[rd_ptr].pc    : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, instr: rsp_data};
  end

  // NOTE: all state updates use non-blocking assignments so every counter
  // sees the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Whatever is in flight, including a response arriving now, is owed one drop.
      req_pc      <= redirect_base;
      rsp_pc      <= redirect_base;
      drop_cnt    <= drop_cnt + outstanding - CW'(rsp_valid);
      outstanding <= '0;
      count       <= '0;
      rd_ptr      <= wr_ptr;
    end else begin
      if (fire) req_pc <= req_pc + 32'd4;
      outstanding <= outstanding + CW'(fire) - CW'(push);
      drop_cnt    <= drop_cnt - CW'(rsp_drop);
      count       <= count + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && rsp_valid) begin
      assert (({1'b0, outstanding} + {1'b0, drop_cnt}) != '0)
        else $error("fetch: response with nothing in flight");
      assert (!(push && count == CW'(DEPTH)))
        else $error("fetch: push into full queue");
    end
  end

endmodule
